// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network blocks: scheduler FSM states and
// default array dimensions reused by the neuron and synapse datapaths.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_LEAK = 2'd2,
        ST_DONE = 2'd3
    } snn_state_e;

    localparam int SNN_N_NEURONS = 4;
    localparam int SNN_CNT_W     = 8;

endpackage

// File: rtl/snn_rr_arbiter.sv
// Combinational round-robin pick: first set request bit at or above ptr_i,
// wrapping around to bit 0.
module snn_rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [ID_W-1:0] ptr_i,
    output logic            grant_valid_o,
    output logic [ID_W-1:0] grant_id_o
);

    int              idx;
    logic [ID_W-1:0] idx_w;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_id_o    = '0;
        idx           = 0;
        idx_w         = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = ID_W'(idx);
            if (req_i[idx_w]) begin
                grant_valid_o = 1'b1;
                grant_id_o    = idx_w;
            end
        end
    end

endmodule

// File: rtl/snn_step_scheduler.sv
// Time-step controller: latches neuron spikes, snapshots them on step_start,
// feeds them one per handshake to the shared synapse engine, then leaks.
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int N_NEURONS = SNN_N_NEURONS,
    parameter int ID_W      = $clog2(N_NEURONS),
    parameter int CNT_W     = SNN_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_NEURONS-1:0] spike_in,
    input  logic                 step_start,
    output logic                 issue_valid,
    input  logic                 issue_ready,
    output logic [ID_W-1:0]      issue_id,
    output logic                 leak_pulse,
    output logic                 step_done,
    output logic                 busy,
    output logic [CNT_W-1:0]     step_count,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 step_overrun,
    output snn_state_e           state_o
);

    snn_state_e           state_q;
    logic [N_NEURONS-1:0] pending_q;
    logic [N_NEURONS-1:0] snapshot_q;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [CNT_W-1:0]     step_count_q;
    logic [CNT_W-1:0]     drop_count_q;
    logic                 overrun_q;

    logic                 grant_valid;
    logic [ID_W-1:0]      grant_id;
    logic [N_NEURONS-1:0] spikes;
    logic                 start_accept;
    logic                 drop_hit;
    logic                 handshake;
    logic [ID_W-1:0]      rr_ptr_d;

    snn_rr_arbiter #(
        .N    (N_NEURONS),
        .ID_W (ID_W)
    ) u_arb (
        .req_i         (snapshot_q),
        .ptr_i         (rr_ptr_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    // Handshake: issue_valid comes from registered state only; an event is
    // consumed on the cycle where issue_valid and issue_ready are both high.
    assign spikes       = ena ? spike_in : '0;
    assign start_accept = step_start && ena && (state_q == ST_IDLE);
    assign drop_hit     = !start_accept && (|(pending_q & spikes));
    assign issue_valid  = (state_q == ST_SCAN) && grant_valid;
    assign handshake    = issue_valid && issue_ready;
    assign rr_ptr_d     = (grant_id == ID_W'(N_NEURONS - 1)) ? '0 : grant_id + ID_W'(1);

    assign issue_id     = issue_valid ? grant_id : '0;
    assign leak_pulse   = (state_q == ST_LEAK);
    assign step_done    = (state_q == ST_DONE);
    assign busy         = (state_q != ST_IDLE);
    assign step_count   = step_count_q;
    assign drop_count   = drop_count_q;
    assign step_overrun = overrun_q;
    assign state_o      = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            snapshot_q   <= '0;
            rr_ptr_q     <= '0;
            step_count_q <= '0;
            drop_count_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            // Spikes landing on the accepted start edge belong to the next step.
            if (start_accept) begin
                snapshot_q <= pending_q;
                pending_q  <= spikes;
            end else begin
                pending_q <= pending_q | spikes;
            end

            if (drop_hit && (drop_count_q != '1)) begin
                drop_count_q <= drop_count_q + CNT_W'(1);
            end

            if (step_start && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_accept) begin
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!grant_valid) begin
                        state_q <= ST_LEAK;
                    end else if (handshake) begin
                        snapshot_q[grant_id] <= 1'b0;
                        rr_ptr_q             <= rr_ptr_d;
                    end
                end
                ST_LEAK: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    step_count_q <= step_count_q + CNT_W'(1);
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler: table of whole time steps with
// hand-computed grant orders, plus sequences for stalls, drops and reset.
module tb_snn_step_scheduler;
    import snn_pkg::*;

    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int CW   = 8;

    logic            clk;
    logic            rst_n;
    logic            ena;
    logic [N-1:0]    spike_in;
    logic            step_start;
    logic            issue_valid;
    logic            issue_ready;
    logic [ID_W-1:0] issue_id;
    logic            leak_pulse;
    logic            step_done;
    logic            busy;
    logic [CW-1:0]   step_count;
    logic [CW-1:0]   drop_count;
    logic            step_overrun;
    snn_state_e      state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    logic [ID_W-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] sp;
        int           n_ev;
        logic [7:0]   ids;
    } vec_t;

    vec_t tbl[7];

    snn_step_scheduler #(.N_NEURONS(N), .ID_W(ID_W), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .spike_in     (spike_in),
        .step_start   (step_start),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_id     (issue_id),
        .leak_pulse   (leak_pulse),
        .step_done    (step_done),
        .busy         (busy),
        .step_count   (step_count),
        .drop_count   (drop_count),
        .step_overrun (step_overrun),
        .state_o      (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full step with an always-ready engine; ids holds 2-bit grants, first in bits [1:0].
    task automatic run_step(input logic [N-1:0] sp, input int n_ev, input logic [7:0] ids,
                            input logic [CW-1:0] exp_steps, input logic [CW-1:0] exp_drop);
        logic [ID_W-1:0] e;
        issue_ready = 1'b1;
        spike_in    = sp;
        tick();
        spike_in   = '0;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        for (int i = 0; i < n_ev; i++) begin
            exp_q.push_back(ids[i*2 +: 2]);
        end
        for (int i = 0; i < n_ev; i++) begin
            e = exp_q.pop_front();
            chk("grant_valid", 32'(issue_valid), 32'd1);
            chk("grant_id", 32'(issue_id), 32'(e));
            tick();
        end
        chk("scan_empty_valid", 32'(issue_valid), 32'd0);
        chk("scan_busy", 32'(busy), 32'd1);
        tick();
        chk("leak_pulse", 32'(leak_pulse), 32'd1);
        chk("leak_no_done", 32'(step_done), 32'd0);
        tick();
        chk("step_done", 32'(step_done), 32'd1);
        chk("done_no_leak", 32'(leak_pulse), 32'd0);
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("step_count", 32'(step_count), 32'(exp_steps));
        chk("drop_count", 32'(drop_count), 32'(exp_drop));
    endtask

    initial begin
        tbl[0] = '{sp: 4'b0000, n_ev: 0, ids: 8'h00};
        tbl[1] = '{sp: 4'b1011, n_ev: 3, ids: {2'd0, 2'd3, 2'd1, 2'd0}};
        tbl[2] = '{sp: 4'b1111, n_ev: 4, ids: {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[3] = '{sp: 4'b0010, n_ev: 1, ids: {2'd0, 2'd0, 2'd0, 2'd1}};
        tbl[4] = '{sp: 4'b0110, n_ev: 2, ids: {2'd0, 2'd0, 2'd1, 2'd2}};
        tbl[5] = '{sp: 4'b1001, n_ev: 2, ids: {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[6] = '{sp: 4'b0001, n_ev: 1, ids: {2'd0, 2'd0, 2'd0, 2'd0}};

        rst_n       = 1'b0;
        ena         = 1'b1;
        spike_in    = '0;
        step_start  = 1'b0;
        issue_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_steps", 32'(step_count), 32'd0);
        chk("rst_drops", 32'(drop_count), 32'd0);
        chk("rst_overrun", 32'(step_overrun), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 7; r++) begin
            run_step(tbl[r].sp, tbl[r].n_ev, tbl[r].ids, CW'(r + 1), '0);
        end

        // Engine stalls 5 cycles on neuron 2 (rr_ptr is 1 here).
        spike_in = 4'b0100;
        tick();
        spike_in    = '0;
        issue_ready = 1'b0;
        step_start  = 1'b1;
        tick();
        step_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(issue_valid), 32'd1);
            chk("stall_id", 32'(issue_id), 32'd2);
            tick();
        end
        issue_ready = 1'b1;
        chk("stall_release_valid", 32'(issue_valid), 32'd1);
        chk("stall_release_id", 32'(issue_id), 32'd2);
        tick();
        chk("stall_once", 32'(issue_valid), 32'd0);
        tick();
        chk("stall_leak", 32'(leak_pulse), 32'd1);
        tick();
        chk("stall_done", 32'(step_done), 32'd1);
        tick();
        chk("stall_steps", 32'(step_count), 32'd8);

        // Neuron 2 spikes twice: one drop. Start-edge spikes go to the next step.
        spike_in = 4'b0100;
        tick();
        chk("drop_none_yet", 32'(drop_count), 32'd0);
        tick();
        chk("drop_one", 32'(drop_count), 32'd1);
        spike_in   = 4'b0101;
        step_start = 1'b1;
        tick();
        spike_in   = '0;
        step_start = 1'b0;
        chk("start_edge_no_drop", 32'(drop_count), 32'd1);
        chk("late_valid", 32'(issue_valid), 32'd1);
        chk("late_id", 32'(issue_id), 32'd2);
        tick();
        chk("late_single", 32'(issue_valid), 32'd0);
        tick();
        tick();
        tick();
        chk("late_steps", 32'(step_count), 32'd9);
        run_step('0, 2, {2'd0, 2'd0, 2'd2, 2'd0}, 8'd10, 8'd1);

        // Drop counter saturates.
        spike_in = 4'b0001;
        for (int i = 0; i < 260; i++) begin
            tick();
        end
        spike_in = '0;
        chk("drop_sat", 32'(drop_count), 32'd255);

        // step_start while busy is sticky, then async reset mid-handshake.
        issue_ready = 1'b0;
        step_start  = 1'b1;
        tick();
        chk("ovr_clear_before", 32'(step_overrun), 32'd0);
        chk("ovr_scan_valid", 32'(issue_valid), 32'd1);
        tick();
        step_start = 1'b0;
        chk("ovr_set", 32'(step_overrun), 32'd1);
        chk("ovr_still_valid", 32'(issue_valid), 32'd1);
        tick();
        tick();
        chk("ovr_sticky", 32'(step_overrun), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(issue_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_steps", 32'(step_count), 32'd0);
        chk("arst_drops", 32'(drop_count), 32'd0);
        chk("arst_overrun", 32'(step_overrun), 32'd0);
        tick();
        rst_n       = 1'b1;
        issue_ready = 1'b1;
        tick();
        run_step('0, 0, 8'h00, 8'd1, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snn_step_scheduler.md
Name: snn_step_scheduler

Overview:
- Time-step controller for the spiking-neuron network. It sequences spike delivery from N neurons into one shared synapse/weight-accumulate engine.
- Latches spike events from every neuron and, on each step_start, snapshots them.
- Grants the snapshot one event at a time to the shared engine over a valid/ready handshake, in round-robin order.
- Then issues one leak pulse to all neurons and signals step completion. It sits between the neuron array and the shared synapse datapath in the top level.

Parameters:
- N_NEURONS, 4, number of neurons / spike requesters (2..16).
- ID_W, $clog2(N_NEURONS), width of the granted neuron index.
- CNT_W, 8, width of the step and drop counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design enable; gates spike capture and step_start acceptance.
- spike_in  in  N_NEURONS  one-cycle spike pulses, bit i = neuron i.
- step_start  in  1  one-cycle request to run a time step.
- issue_valid  out  1  spike event offered to the shared synapse engine.
- issue_ready  in  1  engine accepts the event this cycle.
- issue_id  out  ID_W  index of the neuron whose spike is offered.
- leak_pulse  out  1  one-cycle leak strobe to all neurons.
- step_done  out  1  one-cycle end-of-step strobe.
- busy  out  1  high whenever the FSM is not in IDLE.
- step_count  out  CNT_W  completed steps, wraps modulo 2^CNT_W.
- drop_count  out  CNT_W  lost spike events, saturating.
- step_overrun  out  1  sticky: step_start arrived while busy.

Behaviour:
- Async reset (rst_n=0) immediately clears all state, including mid-handshake. All outputs are 0, FSM is IDLE, rr_ptr=0, pending=0, snapshot=0.
- Capture, when ena=1: pending[i] is set when spike_in[i]=1.
  - If pending[i] is already 1 and is not being cleared this cycle, drop_count increments, saturating at all-ones.
  - Several bits dropping in one cycle count as one increment per cycle.
  - When ena=0, spike_in is ignored.
- FSM states: IDLE, SCAN, LEAK, DONE.
- IDLE -> SCAN on step_start & ena.
  - At that edge: snapshot <= pending, and pending <= spike_in captured that same cycle (spikes arriving at the start edge belong to the next step).
  - No drop is counted for that cycle.
- SCAN:
  - If snapshot==0: go to LEAK (a step with no spikes takes 1 cycle in SCAN).
  - Otherwise issue_valid=1 and issue_id = first set snapshot bit searching upward from rr_ptr, wrapping.
  - issue_id and issue_valid stay stable until issue_ready=1.
  - On handshake (valid & ready): clear that snapshot bit, and set rr_ptr <= (issue_id+1) mod N_NEURONS.
  - Next grant is combinational from the updated snapshot, so back-to-back grants sustain 1 event/cycle.
  - issue_valid is registered-state based; it never depends combinationally on issue_ready.
- LEAK: leak_pulse=1 for exactly one cycle -> DONE.
- DONE: step_done=1 for one cycle, step_count increments with wrap -> IDLE.
- Latency with k events and always-ready engine: step_start -> step_done is k+3 cycles.
- step_start while busy: ignored and step_overrun is set (sticky until reset).
- ena only gates new steps and capture; a step in progress always completes.
- rr_ptr persists across steps for fairness.

Decomposition:
- Shared package snn_pkg: FSM state enum (IDLE/SCAN/LEAK/DONE) and the default N_NEURONS/CNT_W constants reused by neuron/synapse blocks.
- Sub-module snn_rr_arbiter: combinational round-robin pick (req vector, ptr) -> (grant_valid, grant_id).
- The scheduler owns pending/snapshot registers, FSM and counters.

Test Plan:
1. Reset then step_start with no spikes -> no issue_valid; leak_pulse at cycle +2, step_done at +3, step_count=1.
2. spike_in=4'b1011 pulsed, then step_start, issue_ready=1 -> issue_id sequence 0,1,3 on consecutive cycles, then leak_pulse, step_done.
3. issue_ready low for 5 cycles during a grant -> issue_valid/issue_id held constant all 5 cycles; event issued exactly once.
4. Fairness: spikes 4'b1111 every step, engine ready -> step 1 order 0,1,2,3; rr_ptr wraps to 0. Then spikes 4'b0110 with rr_ptr=2 -> order 2,1.
5. Neuron 2 spikes twice before step_start -> drop_count=1, only one grant for id 2. Spike arriving on the step_start cycle is granted in the following step, not the current one.
6. step_start during SCAN -> step_overrun=1 and stays 1. rst_n pulsed low mid-SCAN with issue_valid high -> issue_valid drops immediately, all counters read 0.
